output_timing_generator: RTL and testbench
==========================================

OUTPUT_TIMING_GENERATOR -- requirements
Module: output_timing_generator

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 512, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 14, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 178, horizontal sync width in clocks.
REQ-004 SHALL have parameter H_BP, default 0, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 342, active lines per frame.
REQ-006 SHALL have parameters V_FP, default 0; V_SYNC, default 4; V_BP, default 24 (all in lines).
REQ-007 SHALL have parameter SYNC_ACTIVE_LOW, default 1; 1 means hs/vs are low when asserted.
REQ-008 clk  input  1  pixel clock; sole clock.
REQ-009 reset_n  input  1  asynchronous active-low reset.
REQ-010 run  input  1  high enables timing generation; low holds the generator idle at origin.
REQ-011 hs  output  1  horizontal sync at SYNC_ACTIVE_LOW polarity.
REQ-012 vs  output  1  vertical sync at SYNC_ACTIVE_LOW polarity.
REQ-013 de  output  1  active-pixel indicator.
REQ-014 x_out  output  $clog2(H_ACTIVE)  pixel column; y_out  output  $clog2(V_ACTIVE)  pixel row.
REQ-015 frame_start  output  1  one-clock pulse for pixel (0,0); line_start  output  1  one-clock pulse for x=0 of every active line.

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; internal counters h_cnt/v_cnt SHALL be $clog2(H_TOTAL) / $clog2(V_TOTAL) bits wide.
REQ-017 h_cnt SHALL increment each clk while run=1 and wrap from H_TOTAL-1 to 0.
REQ-018 v_cnt SHALL increment when h_cnt wraps, and wrap from V_TOTAL-1 to 0 on the same clock h_cnt wraps.
REQ-019 Horizontal regions by h_cnt: ACTIVE [0,H_ACTIVE-1], FP next H_FP, SYNC next H_SYNC, BP next H_BP; a zero-length region SHALL be skipped without glitch.
REQ-020 Vertical regions by v_cnt follow the same ordering with V_* parameters.
REQ-021 de SHALL be asserted iff both h_cnt and v_cnt lie in their ACTIVE regions.
REQ-022 hs SHALL be asserted iff h_cnt is in the horizontal SYNC region, on every line including vertical blanking.
REQ-023 vs SHALL be asserted iff v_cnt is in the vertical SYNC region, changing only at h_cnt wrap.
REQ-024 All outputs SHALL be registered with exactly one clock latency from the counter state that defines them.
REQ-025 x_out/y_out SHALL equal h_cnt/v_cnt (truncated) while de=1 and SHALL be 0 while de=0.
REQ-026 line_start SHALL pulse when de rises for a line; frame_start SHALL pulse only when line_start pulses with y_out=0.
REQ-027 When run=0, counters SHALL be forced to 0 and, one clock later, de=0, hs/vs inactive, x_out=y_out=0, pulses low.
REQ-028 On run 0->1 the first output cycle SHALL present pixel (0,0) with de=1, line_start=1, frame_start=1, one clock after run is sampled high.
REQ-029 run dropping mid-line or mid-frame SHALL abort immediately (next clock idle); no partial-frame completion.

Reset
REQ-030 reset_n low SHALL asynchronously clear h_cnt, v_cnt, de, x_out, y_out, frame_start, line_start and drive hs/vs inactive (high when SYNC_ACTIVE_LOW=1).
REQ-031 After reset_n release with run=1, behaviour SHALL match REQ-028 from the first sampling clock.

Structure
REQ-032 Mac SE timing constants (512/14/178/0, 342/0/4/24, polarity) SHALL live in shared package video_timing_pkg, also used by the input side.
REQ-033 One sub-module, timing_axis_counter (wrapping counter with region decode and carry-out), SHALL be instantiated twice (horizontal, vertical carry-enabled).

Verification
REQ-034 Defaults, run=1 from reset: de high 512 clocks per line; line period 704 clocks; frame period 704*370=260480 clocks.
REQ-035 Defaults: hs low exactly 178 clocks starting at h_cnt 526; vs low for lines 342..345 (4*704 clocks), edges coincident with line wrap.
REQ-036 Defaults: first active cycle gives x_out=0,y_out=0, frame_start=1; last active gives x_out=511,y_out=341; frame_start count=1 per frame, line_start count=342.
REQ-037 Drop run at x=200,y=100: next clock de=0, hs/vs inactive, x/y=0; re-raise run: pixel (0,0) with frame_start one clock later.
REQ-038 Assert reset_n low mid-sync: outputs inactive immediately (async); with SYNC_ACTIVE_LOW=0, hs/vs reset low.
REQ-039 H_BP=0,V_FP=0 (defaults) plus H_FP=0 override: no glitch on hs, H_TOTAL=690, sync follows active directly.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: Mac SE video timing constants and region decode shared by input and output sides.
package video_timing_pkg;
    localparam int MAC_H_ACTIVE = 512;
    localparam int MAC_H_FP = 14;
    localparam int MAC_H_SYNC = 178;
    localparam int MAC_H_BP = 0;
    localparam int MAC_V_ACTIVE = 342;
    localparam int MAC_V_FP = 0;
    localparam int MAC_V_SYNC = 4;
    localparam int MAC_V_BP = 24;
    localparam bit MAC_SYNC_ACTIVE_LOW = 1'b1;
    typedef enum logic [1:0] {REG_ACTIVE, REG_FP, REG_SYNC, REG_BP} region_e;
    // Zero-length regions fall through to the next comparison, so they never appear.
    function automatic region_e region_of(input int pos, input int act, input int fp, input int sync);
        return pos < act ? REG_ACTIVE : pos < act + fp ? REG_FP : pos < act + fp + sync ? REG_SYNC : REG_BP;
    endfunction
endpackage

// File: rtl/timing_axis_counter.sv
// timing_axis_counter: wrapping position counter with region decode and carry-out at wrap.
module timing_axis_counter import video_timing_pkg::*; #(
    parameter int ACTIVE = MAC_H_ACTIVE,
    parameter int FP = MAC_H_FP,
    parameter int SYNC = MAC_H_SYNC,
    parameter int BP = MAC_H_BP,
    parameter int W = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_run,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output region_e      o_region,
    output logic         o_carry
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    logic [W-1:0] r_cnt;
    assign o_cnt = r_cnt;
    assign o_carry = i_en && int'(r_cnt) == TOTAL - 1;
    assign o_region = region_of(int'(r_cnt), ACTIVE, FP, SYNC);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_cnt <= '0;
        else if (!i_run) r_cnt <= '0;
        else if (i_en) r_cnt <= o_carry ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/output_timing_generator.sv
// output_timing_generator: registered sync/de/coordinates and line/frame pulses driven by a
// horizontal counter and a vertical counter stepped by the horizontal carry.
module output_timing_generator import video_timing_pkg::*; #(
    parameter int H_ACTIVE = MAC_H_ACTIVE,
    parameter int H_FP = MAC_H_FP,
    parameter int H_SYNC = MAC_H_SYNC,
    parameter int H_BP = MAC_H_BP,
    parameter int V_ACTIVE = MAC_V_ACTIVE,
    parameter int V_FP = MAC_V_FP,
    parameter int V_SYNC = MAC_V_SYNC,
    parameter int V_BP = MAC_V_BP,
    parameter bit SYNC_ACTIVE_LOW = MAC_SYNC_ACTIVE_LOW
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        run,
    output logic                        hs,
    output logic                        vs,
    output logic                        de,
    output logic [$clog2(H_ACTIVE)-1:0] x_out,
    output logic [$clog2(V_ACTIVE)-1:0] y_out,
    output logic                        frame_start,
    output logic                        line_start
);
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    region_e w_h_region, w_v_region;
    logic w_h_carry, w_v_carry_unused, w_de, w_line_first;
    timing_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)) u_h (
        .clk(clk), .reset_n(reset_n), .i_run(run), .i_en(1'b1),
        .o_cnt(w_h_cnt), .o_region(w_h_region), .o_carry(w_h_carry)
    );
    timing_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)) u_v (
        .clk(clk), .reset_n(reset_n), .i_run(run), .i_en(w_h_carry),
        .o_cnt(w_v_cnt), .o_region(w_v_region), .o_carry(w_v_carry_unused)
    );
    assign w_de = run && w_h_region == REG_ACTIVE && w_v_region == REG_ACTIVE;
    assign w_line_first = w_de && w_h_cnt == '0;
    // Outputs reflect the counter state of the previous clock; run low forces the idle pattern.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            hs <= SYNC_ACTIVE_LOW;
            vs <= SYNC_ACTIVE_LOW;
            de <= 1'b0;
            x_out <= '0;
            y_out <= '0;
            line_start <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs <= (run && w_h_region == REG_SYNC) ^ SYNC_ACTIVE_LOW;
            vs <= (run && w_v_region == REG_SYNC) ^ SYNC_ACTIVE_LOW;
            de <= w_de;
            x_out <= w_de ? XW'(w_h_cnt) : '0;
            y_out <= w_de ? YW'(w_v_cnt) : '0;
            line_start <= w_line_first;
            frame_start <= w_line_first && w_v_cnt == '0;
        end
endmodule

// File: tb/tb_output_timing_generator.sv
// tb_output_timing_generator: two small-geometry instances checked every cycle against an elapsed-cycle model.
module tb_output_timing_generator;
    localparam int HA1 = 16, HF1 = 0, HS1 = 6, HB1 = 2, VA1 = 5, VF1 = 0, VS1 = 2, VB1 = 3, P1 = 1;
    localparam int HA2 = 10, HF2 = 3, HS2 = 4, HB2 = 0, VA2 = 4, VF2 = 1, VS2 = 2, VB2 = 0, P2 = 0;
    logic clk = 1'b0, reset_n, run, chk_en;
    logic hs1, vs1, de1, fs1, ls1, hs2, vs2, de2, fs2, ls2;
    logic [3:0] x1, x2;
    logic [2:0] y1;
    logic [1:0] y2;
    int n_chk = 0, n_pass = 0, n;
    int c_de, c_ls, c_fs, c_hs, c_vs, hs15, de15, hs16, de16, xl, yl;
    typedef struct {int de; int hs; int vs; int x; int y; int ls; int fs;} exp_t;
    exp_t e1, e2;
    always #5 clk = ~clk;
    output_timing_generator #(.H_ACTIVE(HA1), .H_FP(HF1), .H_SYNC(HS1), .H_BP(HB1), .V_ACTIVE(VA1),
        .V_FP(VF1), .V_SYNC(VS1), .V_BP(VB1), .SYNC_ACTIVE_LOW(P1)) dut1 (
        .clk(clk), .reset_n(reset_n), .run(run), .hs(hs1), .vs(vs1), .de(de1),
        .x_out(x1), .y_out(y1), .frame_start(fs1), .line_start(ls1));
    output_timing_generator #(.H_ACTIVE(HA2), .H_FP(HF2), .H_SYNC(HS2), .H_BP(HB2), .V_ACTIVE(VA2),
        .V_FP(VF2), .V_SYNC(VS2), .V_BP(VB2), .SYNC_ACTIVE_LOW(P2)) dut2 (
        .clk(clk), .reset_n(reset_n), .run(run), .hs(hs2), .vs(vs2), .de(de2),
        .x_out(x2), .y_out(y2), .frame_start(fs2), .line_start(ls2));
    function automatic exp_t pixel(int k, int ha, int hf, int hsw, int hb, int va, int vf, int vsw, int vb, int pol);
        exp_t e;
        int h, v;
        h = k % (ha + hf + hsw + hb);
        v = (k / (ha + hf + hsw + hb)) % (va + vf + vsw + vb);
        e.de = int'(h < ha && v < va);
        e.hs = int'(h >= ha + hf && h < ha + hf + hsw) ^ pol;
        e.vs = int'(v >= va + vf && v < va + vf + vsw) ^ pol;
        e.x = e.de != 0 ? h : 0;
        e.y = e.de != 0 ? v : 0;
        e.ls = int'(e.de != 0 && h == 0);
        e.fs = int'(e.ls != 0 && v == 0);
        return e;
    endfunction
    function automatic exp_t idle(int pol);
        exp_t e;
        e.de = 0; e.hs = pol; e.vs = pol; e.x = 0; e.y = 0; e.ls = 0; e.fs = 0;
        return e;
    endfunction
    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask
    // Model: output after the k-th consecutive run-high clock is pixel k of the raster.
    always @(posedge clk or negedge reset_n)
        if (!reset_n || !run) begin
            n <= 0;
            e1 <= idle(P1);
            e2 <= idle(P2);
        end else begin
            e1 <= pixel(n, HA1, HF1, HS1, HB1, VA1, VF1, VS1, VB1, P1);
            e2 <= pixel(n, HA2, HF2, HS2, HB2, VA2, VF2, VS2, VB2, P2);
            n <= n + 1;
        end
    always @(negedge clk)
        if (chk_en) begin
            check("d1_de", int'(de1), e1.de); check("d1_hs", int'(hs1), e1.hs); check("d1_vs", int'(vs1), e1.vs);
            check("d1_x", int'(x1), e1.x); check("d1_y", int'(y1), e1.y);
            check("d1_ls", int'(ls1), e1.ls); check("d1_fs", int'(fs1), e1.fs);
            check("d2_de", int'(de2), e2.de); check("d2_hs", int'(hs2), e2.hs); check("d2_vs", int'(vs2), e2.vs);
            check("d2_x", int'(x2), e2.x); check("d2_y", int'(y2), e2.y);
            check("d2_ls", int'(ls2), e2.ls); check("d2_fs", int'(fs2), e2.fs);
        end
    initial begin
        reset_n = 1'b1; run = 1'b0; chk_en = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_d1_hs", int'(hs1), 1); check("rst_d1_vs", int'(vs1), 1); check("rst_d1_de", int'(de1), 0);
        check("rst_d2_hs", int'(hs2), 0); check("rst_d2_vs", int'(vs2), 0); check("rst_d1_fs", int'(fs1), 0);
        chk_en = 1'b1;
        run = 1'b1;
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        check("first_de", int'(de1), 1); check("first_x", int'(x1), 0); check("first_y", int'(y1), 0);
        check("first_fs", int'(fs1), 1); check("first_ls", int'(ls1), 1); check("first_d2_fs", int'(fs2), 1);
        c_de = 0; c_ls = 0; c_fs = 0; c_hs = 0; c_vs = 0;
        for (int i = 0; i < 240; i++) begin
            c_de += int'(de1); c_ls += int'(ls1); c_fs += int'(fs1);
            c_hs += int'(!hs1); c_vs += int'(!vs1);
            if (i == 15) begin hs15 = int'(hs1); de15 = int'(de1); end
            if (i == 16) begin hs16 = int'(hs1); de16 = int'(de1); end
            if (i == 111) begin xl = int'(x1); yl = int'(y1); end
            @(negedge clk);
        end
        check("frame_de_cnt", c_de, 80); check("frame_ls_cnt", c_ls, 5); check("frame_fs_cnt", c_fs, 1);
        check("frame_hs_low", c_hs, 60); check("frame_vs_low", c_vs, 48);
        check("h15_hs", hs15, 1); check("h15_de", de15, 1); check("h16_hs", hs16, 0); check("h16_de", de16, 0);
        check("last_x", xl, 15); check("last_y", yl, 4); check("frame2_fs", int'(fs1), 1);
        repeat (55) @(negedge clk);
        check("pre_drop_x", int'(x1), 7); check("pre_drop_y", int'(y1), 2); check("pre_drop_de", int'(de1), 1);
        run = 1'b0;
        @(negedge clk);
        check("drop_de", int'(de1), 0); check("drop_x", int'(x1), 0); check("drop_y", int'(y1), 0);
        check("drop_hs", int'(hs1), 1); check("drop_vs", int'(vs1), 1); check("drop_d2_hs", int'(hs2), 0);
        run = 1'b1;
        @(negedge clk);
        check("rerun_de", int'(de1), 1); check("rerun_fs", int'(fs1), 1); check("rerun_ls", int'(ls1), 1);
        check("rerun_x", int'(x1), 0); check("rerun_y", int'(y1), 0);
        repeat (64) @(negedge clk);
        check("sync_d1_hs", int'(hs1), 0); check("sync_d2_hs", int'(hs2), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_d1_hs", int'(hs1), 1); check("async_d1_de", int'(de1), 0);
        check("async_d2_hs", int'(hs2), 0); check("async_d2_vs", int'(vs2), 0); check("async_d2_x", int'(x2), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        run = 1'b0;
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
